// File: rtl/compliance_pkg.sv
// Purpose: shared constants for the compliance RAM arbiter slice (default bus widths, host indices).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package compliance_pkg;

  localparam int DefaultAddrWidth = 32;
  localparam int DefaultDataWidth = 32;

  // Fixed host slots on the arbiter.
  localparam int HostCore     = 0;
  localparam int HostTestutil = 1;

  // Host ID width; a single bit even when only one host would fit.
  function automatic int id_width(input int nr_hosts);
    return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
  endfunction

endpackage

// File: rtl/compliance_mem_arb_idfifo.sv
// Purpose: in-order FIFO of host IDs for granted-but-unanswered RAM requests.
// Latency: push visible at head the next cycle; pop takes effect at the clock edge.
// Backpressure: full/empty flags; a push while full or a pop while empty is ignored.
// Ports: clk_i/rst_ni clock and async active-low reset; push/push_id write side;
//        pop read side; full/empty status; head = oldest stored ID.
module compliance_mem_arb_idfifo #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/compliance_mem_arb.sv
// Purpose: round-robin arbiter of several bus hosts onto one single-port RAM, routing responses to their owner.
// Latency: request->grant combinational (0 cycles); response->host combinational, in grant order.
// Backpressure: a pending ungranted request is locked until dev_gnt_i; no requests while the owner FIFO is full.
// Ports: host_* per-host request side (packed, host 0 in LSBs), shared host_rdata_o;
//        dev_* single RAM device port; clk_i/rst_ni clock and async active-low reset.
module compliance_mem_arb
  import compliance_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = DefaultAddrWidth,
  parameter int DataWidth      = DefaultDataWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrHosts-1:0]             host_req_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [DataWidth-1:0]           host_rdata_o,
  output logic [NrHosts-1:0]             host_err_o,
  output logic                           dev_req_o,
  output logic                           dev_we_o,
  output logic [AddrWidth-1:0]           dev_addr_o,
  output logic [DataWidth-1:0]           dev_wdata_o,
  output logic [DataWidth/8-1:0]         dev_be_o,
  input  logic                           dev_gnt_i,
  input  logic                           dev_rvalid_i,
  input  logic [DataWidth-1:0]           dev_rdata_i,
  input  logic                           dev_err_i
);

  localparam int IdW = id_width(NrHosts);
  localparam int BeW = DataWidth / 8;

  logic [IdW-1:0] rr_next;     // first host examined by the next search
  logic [IdW-1:0] arb_sel;
  logic [IdW-1:0] sel;
  logic [IdW-1:0] lock_id;
  logic [IdW-1:0] fifo_head;
  logic           lock_vld;
  logic           arb_found;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           resp_vld;
  int unsigned    cand;

  // Round-robin search starting just after the most recently granted host.
  always_comb begin
    arb_sel   = rr_next;
    arb_found = 1'b0;
    cand      = 0;
    for (int k = 0; k < NrHosts; k++) begin
      cand = (32'(rr_next) + 32'(k)) % 32'(NrHosts);
      if (!arb_found && host_req_i[IdW'(cand)]) begin
        arb_sel   = IdW'(cand);
        arb_found = 1'b1;
      end
    end
  end

  // A refused request keeps its host selected so the RAM sees stable fields until it grants.
  assign sel = lock_vld ? lock_id : arb_sel;

  assign dev_req_o   = (|host_req_i) & ~fifo_full;
  assign accept      = dev_req_o & dev_gnt_i;
  assign dev_we_o    = host_we_i[sel];
  assign dev_addr_o  = host_addr_i[sel*AddrWidth +: AddrWidth];
  assign dev_wdata_o = host_wdata_i[sel*DataWidth +: DataWidth];
  assign dev_be_o    = host_be_i[sel*BeW +: BeW];

  // A response with no owner on record is dropped rather than routed to a stale head.
  assign resp_vld     = dev_rvalid_i & ~fifo_empty;
  assign host_rdata_o = dev_rdata_i;

  always_comb begin
    host_gnt_o            = '0;
    host_rvalid_o         = '0;
    host_err_o            = '0;
    host_gnt_o[sel]       = accept;
    host_rvalid_o[fifo_head] = resp_vld;
    host_err_o[fifo_head]    = resp_vld & dev_err_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_next  <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (accept) begin
      rr_next  <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1);
      lock_vld <= 1'b0;
    end else if (dev_req_o) begin
      lock_vld <= 1'b1;
      lock_id  <= sel;
    end
  end

  compliance_mem_arb_idfifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (accept),
    .push_id (sel),
    .pop     (dev_rvalid_i),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  for (genvar i = 0; i < NrHosts; i++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (host_req_i[i] && !host_gnt_o[i]) |=> host_req_i[i]);
  end

  a_gnt_onehot:    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_rvalid_o));
  a_no_empty_pop:  assert property (@(posedge clk_i) disable iff (!rst_ni) dev_rvalid_i |-> !fifo_empty);

endmodule
